l1_rd_arb: RTL and testbench

L1_RD_ARB -- requirements
Module: l1_rd_arb

---
 rtl/l1_pkg.sv | 14 +
 rtl/base_emux_le.sv | 12 +
 rtl/l1_rd_arb_pack.sv | 38 +++
 rtl/l1_rd_arb.sv | 125 ++++++++++++
 tb/tb_l1_rd_arb.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_pkg.sv
// Shared defaults and width helpers for the L1 read arbiter slice.
package l1_pkg;
  localparam int NREQ_DEF   = 16;
  localparam int NPORTS_DEF = 8;
  localparam int NSTRMS_DEF = 64;

  function automatic int nstrms_width(input int nstrms);
    return (nstrms > 1) ? $clog2(nstrms) : 1;
  endfunction

  function automatic int reqid_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction
endpackage

// File: rtl/base_emux_le.sv
// Little-endian indexed mux: way 0 occupies the least significant bits of din_i.
module base_emux_le #(
  parameter int ways  = 2,
  parameter int width = 1,
  parameter int selw  = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic [ways*width-1:0] din_i,
  input  logic [selw-1:0]       sel_i,
  output logic [width-1:0]      dout_o
);
  assign dout_o = din_i[sel_i*width +: width];
endmodule

// File: rtl/l1_rd_arb_pack.sv
// Rotate/select/pack: scans requesters from rr, packs the first nports live ones onto ports 0..n-1.
module l1_rd_arb_pack
  import l1_pkg::*;
#(
  parameter int nreq   = NREQ_DEF,
  parameter int nports = NPORTS_DEF,
  localparam int RW    = reqid_width(nreq)
) (
  input  logic [nreq-1:0]      req_v_i,
  input  logic [nreq-1:0]      req_end_i,
  input  logic [RW-1:0]        rr_i,
  output logic [nports*RW-1:0] port_idx_o,
  output logic [nports-1:0]    port_v_o,
  output logic [nreq-1:0]      drop_o
);
  always_comb begin
    logic [RW-1:0] j;
    int            rank;
    port_idx_o = '0;
    port_v_o   = '0;
    drop_o     = req_v_i & req_end_i;
    j          = '0;
    rank       = 0;
    for (int s = 0; s < nreq; s++) begin
      j = RW'((int'(rr_i) + s) % nreq);
      if (req_v_i[j] && !req_end_i[j]) begin
        // rank counts live requesters already seen; it doubles as the target port
        for (int k = 0; k < nports; k++) begin
          if (rank == k) begin
            port_idx_o[k*RW +: RW] = j;
            port_v_o[k]            = 1'b1;
          end
        end
        rank = rank + 1;
      end
    end
  end
endmodule

// File: rtl/l1_rd_arb.sv
// Round-robin arbiter from nreq AFU read requesters onto nports packed L1 read ports.
// Ports reload all-or-nothing once every slot is empty or draining; ended-stream requests are dropped and counted.
module l1_rd_arb
  import l1_pkg::*;
#(
  parameter int nreq   = NREQ_DEF,
  parameter int nports = NPORTS_DEF,
  parameter int nstrms = NSTRMS_DEF,
  localparam int SW    = nstrms_width(nstrms),
  localparam int RW    = reqid_width(nreq)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nreq-1:0]      i_req_v,
  output logic [nreq-1:0]      i_req_r,
  input  logic [nreq*SW-1:0]   i_req_sid,
  input  logic [nstrms-1:0]    i_l1_end,
  output logic [nports-1:0]    o_rd_v,
  input  logic [nports-1:0]    o_rd_r,
  output logic [nports*SW-1:0] o_rd_sid,
  output logic [nports*RW-1:0] o_rd_reqid,
  output logic [15:0]          o_drop_cnt
);
  logic [nreq-1:0]      req_end, drop, sel;
  logic [nports*RW-1:0] port_idx;
  logic [nports-1:0]    port_v;
  logic [nports-1:0]    v_q, v_d;
  logic [nports*SW-1:0] sid_q, sid_d;
  logic [nports*RW-1:0] rid_q, rid_d;
  logic [RW-1:0]        rr_q, rr_d, last_idx;
  logic [15:0]          cnt_q, cnt_d;
  logic [16:0]          ndrop, cnt_sum;
  logic                 load_en;

  for (genvar j = 0; j < nreq; j++) begin : g_end
    base_emux_le #(.ways(nstrms), .width(1)) u_end_mux (
      .din_i  (i_l1_end),
      .sel_i  (i_req_sid[j*SW +: SW]),
      .dout_o (req_end[j])
    );
  end

  l1_rd_arb_pack #(.nreq(nreq), .nports(nports)) u_pack (
    .req_v_i    (i_req_v),
    .req_end_i  (req_end),
    .rr_i       (rr_q),
    .port_idx_o (port_idx),
    .port_v_o   (port_v),
    .drop_o     (drop)
  );

  assign load_en = &(~v_q | o_rd_r);

  always_comb begin
    sel      = '0;
    last_idx = '0;
    for (int k = 0; k < nports; k++) begin
      if (port_v[k]) begin
        sel[port_idx[k*RW +: RW]] = 1'b1;
        last_idx                  = port_idx[k*RW +: RW];
      end
    end
  end

  assign i_req_r = reset ? '0 : ((sel | drop) & {nreq{load_en}});

  always_comb begin
    ndrop = '0;
    for (int j = 0; j < nreq; j++) begin
      if (drop[j]) ndrop = ndrop + 17'd1;
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + (load_en ? ndrop : 17'd0);
  assign cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // Pointer only moves when a live requester was actually granted.
  always_comb begin
    rr_d = rr_q;
    if (load_en && port_v[0]) begin
      rr_d = (last_idx == RW'(nreq - 1)) ? '0 : last_idx + RW'(1);
    end
  end

  always_comb begin
    v_d   = v_q;
    sid_d = sid_q;
    rid_d = rid_q;
    if (load_en) begin
      v_d = port_v;
      for (int k = 0; k < nports; k++) begin
        if (port_v[k]) begin
          sid_d[k*SW +: SW] = i_req_sid[port_idx[k*RW +: RW]*SW +: SW];
          rid_d[k*RW +: RW] = port_idx[k*RW +: RW];
        end else begin
          sid_d[k*SW +: SW] = '0;
          rid_d[k*RW +: RW] = '0;
        end
      end
    end else begin
      v_d = v_q & ~o_rd_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      sid_q <= '0;
      rid_q <= '0;
      rr_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      sid_q <= sid_d;
      rid_q <= rid_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_rd_v     = v_q;
  assign o_rd_sid   = sid_q;
  assign o_rd_reqid = rid_q;
  assign o_drop_cnt = cnt_q;
endmodule

// File: tb/tb_l1_rd_arb.sv
// Randomized and directed bench for l1_rd_arb with a queue-based reference model and scoreboard.
module tb_l1_rd_arb;
  localparam int NREQ = 16, NPORTS = 8, NSTRMS = 64, SW = 6, RW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      i_req_v;
  logic [NREQ-1:0]      i_req_r;
  logic [NREQ*SW-1:0]   i_req_sid;
  logic [NSTRMS-1:0]    i_l1_end;
  logic [NPORTS-1:0]    o_rd_v;
  logic [NPORTS-1:0]    o_rd_r;
  logic [NPORTS*SW-1:0] o_rd_sid;
  logic [NPORTS*RW-1:0] o_rd_reqid;
  logic [15:0]          o_drop_cnt;

  l1_rd_arb #(.nreq(NREQ), .nports(NPORTS), .nstrms(NSTRMS)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req_v    (i_req_v),
    .i_req_r    (i_req_r),
    .i_req_sid  (i_req_sid),
    .i_l1_end   (i_l1_end),
    .o_rd_v     (o_rd_v),
    .o_rd_r     (o_rd_r),
    .o_rd_sid   (o_rd_sid),
    .o_rd_reqid (o_rd_reqid),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] req_r;
  } req_exp_t;

  typedef struct {
    int                   cyc;
    logic [NPORTS-1:0]    v;
    logic [NPORTS*SW-1:0] sid;
    logic [NPORTS*RW-1:0] rid;
    logic [15:0]          drop;
    bit                   full;
  } out_exp_t;

  req_exp_t q_req[$];
  out_exp_t q_out[$];
  int checks = 0;
  int errors = 0;

  // Reference state: the port bank as seen from outside, pointer and drop total.
  bit         m_v[NPORTS];
  logic [5:0] m_sid[NPORTS];
  logic [3:0] m_rid[NPORTS];
  int         m_rr = 0;
  int         m_drop = 0;

  // Stimulus for the next cycle.
  bit          st_rst;
  logic [15:0] st_v;
  logic [5:0]  st_sid[NREQ];
  logic [63:0] st_end;
  logic [7:0]  st_rdr;

  task automatic step();
    req_exp_t re;
    out_exp_t oe;
    int       live[$];
    logic [NREQ-1:0] dropm;
    bit       load;
    int       nsel;
    @(posedge clk);
    #1;
    reset    = st_rst;
    i_req_v  = st_v;
    i_l1_end = st_end;
    o_rd_r   = st_rdr;
    for (int j = 0; j < NREQ; j++) i_req_sid[j*SW +: SW] = st_sid[j];

    re.cyc   = cyc;
    re.req_r = '0;
    oe.full  = 1'b0;
    if (st_rst) begin
      for (int k = 0; k < NPORTS; k++) begin
        m_v[k] = 1'b0; m_sid[k] = '0; m_rid[k] = '0;
      end
      m_rr    = 0;
      m_drop  = 0;
      oe.full = 1'b1;
    end else begin
      load  = 1'b1;
      dropm = '0;
      for (int k = 0; k < NPORTS; k++) if (m_v[k] && !st_rdr[k]) load = 1'b0;
      for (int s = 0; s < NREQ; s++) begin
        int j;
        j = (m_rr + s) % NREQ;
        if (st_v[j]) begin
          if (st_end[st_sid[j]]) dropm[j] = 1'b1;
          else live.push_back(j);
        end
      end
      if (load) begin
        nsel     = (live.size() < NPORTS) ? live.size() : NPORTS;
        re.req_r = dropm;
        for (int k = 0; k < NPORTS; k++) begin
          if (k < nsel) begin
            re.req_r[live[k]] = 1'b1;
            m_v[k]   = 1'b1;
            m_sid[k] = st_sid[live[k]];
            m_rid[k] = 4'(live[k]);
          end else begin
            m_v[k] = 1'b0;
          end
        end
        if (nsel > 0) m_rr = (live[nsel-1] + 1) % NREQ;
        m_drop = m_drop + $countones(dropm);
        if (m_drop > 65535) m_drop = 65535;
      end else begin
        for (int k = 0; k < NPORTS; k++) if (m_v[k] && st_rdr[k]) m_v[k] = 1'b0;
      end
    end
    q_req.push_back(re);

    oe.cyc  = cyc + 1;
    oe.drop = 16'(m_drop);
    for (int k = 0; k < NPORTS; k++) begin
      oe.v[k]              = m_v[k];
      oe.sid[k*SW +: SW]   = m_sid[k];
      oe.rid[k*RW +: RW]   = m_rid[k];
    end
    q_out.push_back(oe);
  endtask

  // Monitor: compares whatever the scoreboard holds for the current cycle.
  always @(negedge clk) begin
    req_exp_t r;
    out_exp_t o;
    while (q_req.size() > 0 && q_req[0].cyc == cyc) begin
      r = q_req.pop_front();
      checks++;
      if (i_req_r !== r.req_r) begin
        errors++;
        $display("FAIL req_r cyc=%0d got=%h exp=%h", cyc, i_req_r, r.req_r);
      end
    end
    while (q_out.size() > 0 && q_out[0].cyc == cyc) begin
      o = q_out.pop_front();
      checks++;
      if (o_rd_v !== o.v) begin
        errors++;
        $display("FAIL rd_v cyc=%0d got=%b exp=%b", cyc, o_rd_v, o.v);
      end
      checks++;
      if (o_drop_cnt !== o.drop) begin
        errors++;
        $display("FAIL drop_cnt cyc=%0d got=%0d exp=%0d", cyc, o_drop_cnt, o.drop);
      end
      for (int k = 0; k < NPORTS; k++) begin
        if (o.full || o.v[k]) begin
          checks++;
          if (o_rd_sid[k*SW +: SW] !== o.sid[k*SW +: SW] ||
              o_rd_reqid[k*RW +: RW] !== o.rid[k*RW +: RW]) begin
            errors++;
            $display("FAIL port%0d cyc=%0d got sid=%0d reqid=%0d exp sid=%0d reqid=%0d",
                     k, cyc, o_rd_sid[k*SW +: SW], o_rd_reqid[k*RW +: RW],
                     o.sid[k*SW +: SW], o.rid[k*RW +: RW]);
          end
        end
      end
    end
  end

  task automatic distinct_sids();
    for (int j = 0; j < NREQ; j++) st_sid[j] = 6'(j);
  endtask

  task automatic set_rand();
    st_rst = ($urandom_range(0, 49) == 0);
    case ($urandom_range(0, 2))
      0:       st_v = 16'($urandom);
      1:       st_v = 16'($urandom & $urandom);
      default: st_v = 16'($urandom | $urandom);
    endcase
    for (int j = 0; j < NREQ; j++) st_sid[j] = 6'($urandom_range(0, NSTRMS - 1));
    st_end = {$urandom & $urandom, $urandom & $urandom};
    st_rdr = 8'($urandom | $urandom);
  endtask

  initial begin
    reset = 1'b1; i_req_v = '0; i_req_sid = '0; i_l1_end = '0; o_rd_r = '0;
    st_v = '0; st_end = '0; st_rdr = '0; distinct_sids();

    st_rst = 1'b1; step(); step();

    // All valid, distinct live streams, every port ready: 0-7, 8-15, then wraps to 0-7.
    st_rst = 1'b0; st_v = 16'hFFFF; st_rdr = 8'hFF;
    step(); step(); step();

    // Drive rr to 5, then only requesters 3 and 12 valid.
    st_v = 16'h001F; step();
    st_v = 16'h1008; step();
    st_v = 16'h0000; step();

    // Port 2 stalled for four cycles with requests pending.
    st_v = 16'hFFFF; st_rdr = 8'hFF; step();
    st_rdr = 8'hFB; repeat (4) step();
    st_rdr = 8'hFF; step();
    st_v = 16'h0000; step();

    // Stream of requester 1 ended after a fresh reset.
    st_rst = 1'b1; step();
    st_rst = 1'b0; st_v = 16'h000F; st_end = 64'h2; step();
    st_v = 16'h0000; st_end = '0; step();

    repeat (400) begin
      set_rand(); step();
    end

    // Reset with five slots held valid, then the next grant begins at requester 0.
    st_rst = 1'b0; distinct_sids(); st_end = '0;
    st_rst = 1'b1; step();
    st_rst = 1'b0; st_v = 16'h001F; st_rdr = 8'h00; step(); step();
    st_rst = 1'b1; st_v = 16'hFFFF; step();
    st_rst = 1'b0; st_rdr = 8'hFF; step(); step();

    // Saturate the drop counter, then keep dropping.
    st_v = 16'hFFFF; st_end = '1;
    repeat (4096) step();
    st_v = 16'h0007; repeat (3) step();
    st_v = 16'h0000; st_end = '0; step();

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
